// File: rtl/fp_normalizer_pkg.sv
// ---------------------------------------------------------------------------
// fp_normalizer_pkg
//   Shared definitions for the single-precision post-add normalizer.
//   Holds the IEEE 754 field widths, the exponent ceiling and the state
//   encoding of the normalizer FSM so the adder and rounder stages can agree
//   on the same numbers.
//
//   Contents:
//     FP_EXP_W     biased exponent width (8)
//     FP_FRAC_W    stored fraction width, hidden bit excluded (23)
//     FP_EXTRA_W   guard/round/sticky bits below the fraction (4)
//     FP_EXP_MAX   all-ones exponent, i.e. infinity (255)
//     norm_state_e FSM states IDLE / EVAL / DONE
// ---------------------------------------------------------------------------
package fp_normalizer_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_EXTRA_W = 4;
  localparam int FP_EXP_MAX = (1 << FP_EXP_W) - 1;

  // Encodings are fixed because the neighbouring datapath stages decode
  // them in their own debug logic.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/fp_normalizer.sv
// ---------------------------------------------------------------------------
// fp_normalizer
//   Iterative post-add normalizer for the single-precision FP datapath. It
//   sits between the mantissa adder/subtractor and the rounder. A carry out
//   of the adder is absorbed by one right shift (sticky preserved); a
//   cancelled sum is shifted left one bit per cycle until the hidden bit is
//   set, or until the exponent bottoms out and the result is subnormal.
//
//   Ports:
//     clk       in   rising-edge clock
//     reset     in   synchronous, active-high; aborts any operation
//     start     in   request, sampled only while idle
//     sign_in   in   sign of the sum
//     exp_in    in   tentative biased exponent
//     mant_in   in   [28]=carry, [27]=hidden, [26:4]=fraction, [3:0]=extra
//     sign_out  out  latched sign
//     exp_out   out  normalized biased exponent
//     mant_out  out  {fraction, extra} for the rounder
//     busy      out  high from the cycle after start until done
//     done      out  one-cycle pulse, results valid and held afterwards
//     zero      out  result is zero
//     overflow  out  exponent hit all-ones, mant_out forced to 0 (infinity)
// ---------------------------------------------------------------------------
module fp_normalizer
  import fp_normalizer_pkg::*;
#(
  parameter int EXP_W   = FP_EXP_W,
  parameter int FRAC_W  = FP_FRAC_W,
  parameter int EXTRA_W = FP_EXTRA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        sign_in,
  input  logic [EXP_W-1:0]            exp_in,
  input  logic [FRAC_W+EXTRA_W+1:0]   mant_in,
  output logic                        sign_out,
  output logic [EXP_W-1:0]            exp_out,
  output logic [FRAC_W+EXTRA_W-1:0]   mant_out,
  output logic                        busy,
  output logic                        done,
  output logic                        zero,
  output logic                        overflow
);

  localparam int MANT_W  = FRAC_W + EXTRA_W + 2;
  localparam int OUT_W   = FRAC_W + EXTRA_W;
  localparam int CARRY_B = MANT_W - 1;
  localparam int HIDDEN_B = MANT_W - 2;

  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_INF  = {EXP_W{1'b1}};

  // Working registers
  norm_state_e         state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;

  // Registered outputs
  logic                signOut_q, signOut_d;
  logic [EXP_W-1:0]    expOut_q, expOut_d;
  logic [OUT_W-1:0]    mantOut_q, mantOut_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                zero_q, zero_d;
  logic                overflow_q, overflow_d;

  // One bit wider than the exponent so the carry case can see the
  // all-ones ceiling (and anything beyond it) without wrapping to zero.
  logic [EXP_W:0]      expInc;
  logic [MANT_W-1:0]   mantRight;

  // Exponent increment and sticky-preserving right shift for the carry
  // case. The two bits shifted out are OR-ed into the new LSB so the
  // rounder still sees that something nonzero was lost.
  always_comb begin
    expInc    = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
    mantRight = {1'b0, mant_q[CARRY_B:2], mant_q[1] | mant_q[0]};
  end

  // Next-state logic. Every register holds by default; EVAL takes exactly
  // one action per cycle, checked in priority order: zero, carry, already
  // normal, exponent exhausted (subnormal), otherwise shift left once.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    signOut_d  = signOut_q;
    expOut_d   = expOut_q;
    mantOut_d  = mantOut_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d     = sign_in;
          exp_d      = exp_in;
          mant_d     = mant_in;
          zero_d     = 1'b0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = EVAL;
        end
      end

      EVAL: begin
        if (mant_q == '0) begin
          exp_d   = EXP_ZERO;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (mant_q[CARRY_B]) begin
          if (expInc >= {1'b0, EXP_INF}) begin
            exp_d      = EXP_INF;
            mant_d     = '0;
            overflow_d = 1'b1;
          end else begin
            exp_d  = expInc[EXP_W-1:0];
            mant_d = mantRight;
          end
          state_d = DONE;
        end else if (mant_q[HIDDEN_B]) begin
          state_d = DONE;
        end else if (exp_q <= EXP_ONE) begin
          // The exponent cannot go lower: leave the mantissa as it is and
          // report a subnormal with the reserved zero exponent.
          exp_d   = EXP_ZERO;
          state_d = DONE;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end
      end

      DONE: begin
        // Start is deliberately not looked at here; a request arriving
        // while the result is being published is dropped.
        done_d    = 1'b1;
        busy_d    = 1'b0;
        signOut_d = sign_q;
        expOut_d  = exp_q;
        mantOut_d = mant_q[OUT_W-1:0];
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and wins over a
  // simultaneous start; it aborts a running operation with no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      signOut_q  <= 1'b0;
      expOut_q   <= '0;
      mantOut_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      signOut_q  <= signOut_d;
      expOut_q   <= expOut_d;
      mantOut_q  <= mantOut_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign sign_out = signOut_q;
  assign exp_out  = expOut_q;
  assign mant_out = mantOut_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// ---------------------------------------------------------------------------
// tb_fp_normalizer
//   Scoreboard bench for fp_normalizer. The driver pushes the reference
//   result of every accepted request into a queue; an independent monitor
//   pops and compares whenever done is seen. The reference model works
//   from the position of the leading one rather than stepping the shifter.
// ---------------------------------------------------------------------------
module tb_fp_normalizer;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] mant;
    logic        zero;
    logic        ovf;
    int          lat;
    int          startCyc;
  } expect_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signIn = 1'b0;
  logic [7:0]  expIn = '0;
  logic [28:0] mantIn = '0;
  logic        signOut;
  logic [7:0]  expOut;
  logic [26:0] mantOut;
  logic        busy;
  logic        done;
  logic        zero;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;
  expect_t expQ[$];

  fp_normalizer dut (
    .clk      (clock),
    .reset    (reset),
    .start    (start),
    .sign_in  (signIn),
    .exp_in   (expIn),
    .mant_in  (mantIn),
    .sign_out (signOut),
    .exp_out  (expOut),
    .mant_out (mantOut),
    .busy     (busy),
    .done     (done),
    .zero     (zero),
    .overflow (overflow)
  );

  // Free-running clock and edge counter used for latency checks
  always #5 clock = ~clock;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Single comparison point: every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: find the leading one, work out how many left shifts
  // are needed and how many the exponent can afford, and derive the result
  // and the latency directly from those two numbers.
  function automatic expect_t refModel(input logic s, input int e, input logic [28:0] m);
    expect_t r;
    logic [28:0] shifted;
    int msb;
    int need;
    int k;
    r.sign = s;
    r.zero = 1'b0;
    r.ovf  = 1'b0;
    r.lat  = 2;
    r.startCyc = 0;
    if (m == 29'd0) begin
      r.exp  = 8'd0;
      r.mant = 27'd0;
      r.zero = 1'b1;
    end else if (m[28]) begin
      if (e + 1 >= 255) begin
        r.exp  = 8'd255;
        r.mant = 27'd0;
        r.ovf  = 1'b1;
      end else begin
        r.exp   = 8'(e + 1);
        shifted = (m >> 1) | (m & 29'd1);
        r.mant  = shifted[26:0];
      end
    end else begin
      msb = 0;
      for (int i = 0; i <= 27; i++) if (m[i]) msb = i;
      need = 27 - msb;
      if (need == 0 || e > need) begin
        k     = need;
        r.exp = 8'(e - need);
      end else begin
        k     = (e > 1) ? e - 1 : 0;
        r.exp = 8'd0;
      end
      shifted = m << k;
      r.mant  = shifted[26:0];
      r.lat   = 2 + k;
    end
    return r;
  endfunction

  // Issue one request, record its expectation, optionally poke a start in
  // while busy, and wait (bounded) for done.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [28:0] m,
                               input int intrudeAt);
    expect_t x;
    int waitCnt;
    x = refModel(s, int'(e), m);
    @(negedge clock);
    x.startCyc = cycleCnt + 1;
    expQ.push_back(x);
    signIn = s;
    expIn  = e;
    mantIn = m;
    start  = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    waitCnt = 0;
    while (done !== 1'b1 && waitCnt < 80) begin
      if (waitCnt + 1 == intrudeAt) begin
        start  = 1'b1;
        signIn = ~s;
        expIn  = 8'd10;
        mantIn = 29'h0800_0000;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      waitCnt++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      checkOutput("doneTimeout", 32'(done), 32'd1);
      if (expQ.size() > 0) void'(expQ.pop_back());
    end
  endtask

  // Monitor: compares every done against the oldest outstanding expectation
  always @(negedge clock) begin
    expect_t x;
    if (reset === 1'b0 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'(done), 32'd0);
      end else begin
        x = expQ.pop_front();
        checkOutput("signOut",  32'(signOut),  32'(x.sign));
        checkOutput("expOut",   32'(expOut),   32'(x.exp));
        checkOutput("mantOut",  32'(mantOut),  32'(x.mant));
        checkOutput("zero",     32'(zero),     32'(x.zero));
        checkOutput("overflow", 32'(overflow), 32'(x.ovf));
        checkOutput("busyAtDone", 32'(busy), 32'd0);
        checkOutput("latency",  32'(cycleCnt - x.startCyc), 32'(x.lat));
      end
    end
  end

  // Absolute safety net in case something upstream stalls forever
  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit hit");
  end

  // Main sequence: reset, directed corner cases, abort test, random run
  initial begin
    int doneSeen;
    int p;
    logic [31:0] r;
    logic [28:0] m;
    logic [7:0] e;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("resetSign",  32'(signOut),  32'd0);
    checkOutput("resetExp",   32'(expOut),   32'd0);
    checkOutput("resetMant",  32'(mantOut),  32'd0);
    checkOutput("resetBusy",  32'(busy),     32'd0);
    checkOutput("resetDone",  32'(done),     32'd0);
    checkOutput("resetZero",  32'(zero),     32'd0);
    checkOutput("resetOvf",   32'(overflow), 32'd0);

    // Already normal
    applyStimulus(1'b0, 8'd130, 29'h0800_0000, 0);
    checkOutput("c1Exp",  32'(expOut),  32'd130);
    checkOutput("c1Mant", 32'(mantOut), 32'd0);
    checkOutput("c1Zero", 32'(zero),    32'd0);

    // Carry with sticky bits
    applyStimulus(1'b1, 8'd130, 29'h1000_0003, 0);
    checkOutput("c2Exp",  32'(expOut),  32'd131);
    checkOutput("c2Mant", 32'(mantOut), 32'h000_0001);

    // Reset in the middle of a long shift, with an ignored start first
    @(negedge clock);
    signIn = 1'b1;
    expIn  = 8'd150;
    mantIn = 29'h0000_0080;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("abortBusy", 32'(busy), 32'd1);
    repeat (3) @(negedge clock);
    expIn  = 8'd10;
    mantIn = 29'h0800_0000;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("ignoredStartBusy", 32'(busy), 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abortSign", 32'(signOut),  32'd0);
    checkOutput("abortExp",  32'(expOut),   32'd0);
    checkOutput("abortMant", 32'(mantOut),  32'd0);
    checkOutput("abortBusyClr", 32'(busy),  32'd0);
    checkOutput("abortZero", 32'(zero),     32'd0);
    checkOutput("abortOvf",  32'(overflow), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) doneSeen++;
      @(negedge clock);
    end
    checkOutput("noDoneAfterAbort", 32'(doneSeen), 32'd0);

    // Same 20-shift request again, run to completion
    applyStimulus(1'b1, 8'd150, 29'h0000_0080, 0);
    checkOutput("longExp", 32'(expOut), 32'd130);

    // 20-shift request with a start poked in while busy
    applyStimulus(1'b0, 8'd150, 29'h0000_0080, 4);
    checkOutput("intrudedExp",  32'(expOut),  32'd130);
    checkOutput("intrudedSign", 32'(signOut), 32'd0);

    // Three left shifts
    applyStimulus(1'b0, 8'd130, 29'h0100_0000, 0);
    checkOutput("c3Exp",  32'(expOut),  32'd127);
    checkOutput("c3Mant", 32'(mantOut), 32'd0);

    // One shift then subnormal
    applyStimulus(1'b0, 8'd2, 29'h0040_0000, 0);
    checkOutput("c4Exp",  32'(expOut),  32'd0);
    checkOutput("c4Mant", 32'(mantOut), 32'h080_0000);

    // Overflow to infinity
    applyStimulus(1'b0, 8'd254, 29'h1000_0000, 0);
    checkOutput("c5Exp",  32'(expOut),   32'd255);
    checkOutput("c5Ovf",  32'(overflow), 32'd1);
    checkOutput("c5Mant", 32'(mantOut),  32'd0);

    // Exact zero
    applyStimulus(1'b1, 8'd77, 29'h0000_0000, 0);
    checkOutput("c5Zero",    32'(zero),     32'd1);
    checkOutput("c5ZeroExp", 32'(expOut),   32'd0);
    checkOutput("c5ZeroOvf", 32'(overflow), 32'd0);

    // Randomized run biased toward the interesting exponent ranges
    for (int n = 0; n < 150; n++) begin
      p = int'($urandom_range(0, 29));
      r = $urandom;
      if (p == 29) m = 29'd0;
      else m = 29'((r & ((32'd1 << p) - 32'd1)) | (32'd1 << p));
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(0, 30));
        1:       e = 8'($urandom_range(240, 254));
        default: e = 8'($urandom_range(0, 254));
      endcase
      applyStimulus(1'($urandom), e, m, int'($urandom_range(0, 6)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
